// File: rtl/au_add_vz_dser.sv
// Digit-serial two's-complement adder: s = a + b + ci with carry-out, overflow and zero flags.
// Latency: out_valid rises exactly NDIG cycles after the accept edge; one operation per NDIG+2 cycles at most.
// Backpressure: result is held in DONE, with s/co/v/z stable, until out_ready; in_ready is high only in IDLE.
module au_add_vz_dser #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             v,
    output logic             z
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // All-ones in the low DIGIT bits; shifted up to select the digit being written.
    localparam logic [WIDTH-1:0] DMASK = WIDTH'({DIGIT{1'b1}});

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;

    logic [31:0]      sh;
    logic [DIGIT-1:0] a_k;
    logic [DIGIT-1:0] b_k;
    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] acc_nxt;
    logic             last;

    // Handshake outputs are pure state decodes, so in_ready is 1 throughout reset.
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // Current digit slice, its sum with the running carry, and the partial sum with that digit inserted.
    always_comb begin
        sh      = 32'(cnt) * 32'(DIGIT);
        a_k     = DIGIT'(a_q >> sh);
        b_k     = DIGIT'(b_q >> sh);
        dsum    = {1'b0, a_k} + {1'b0, b_k} + {{DIGIT{1'b0}}, carry};
        acc_nxt = (acc_q & ~(DMASK << sh)) | (WIDTH'(dsum[DIGIT-1:0]) << sh);
        last    = (cnt == CW'(NDIG - 1));
    end

    // Sequencer: IDLE accepts, BUSY walks the digits, DONE waits for the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state <= ST_BUSY;
                        cnt   <= '0;
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Operand capture on accept, then one digit of sum and carry per BUSY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            acc_q <= '0;
        end else if (state == ST_IDLE) begin
            if (in_valid) begin
                a_q   <= a;
                b_q   <= b;
                carry <= ci;
            end
        end else if (state == ST_BUSY) begin
            acc_q <= acc_nxt;
            carry <= dsum[DIGIT];
        end
    end

    // Result registers load only on the final-digit edge and hold through IDLE and the next BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s  <= '0;
            co <= 1'b0;
            v  <= 1'b0;
            z  <= 1'b0;
        end else if ((state == ST_BUSY) && last) begin
            s  <= acc_nxt;
            co <= dsum[DIGIT];
            v  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) & (acc_nxt[WIDTH-1] != a_q[WIDTH-1]);
            z  <= ~|acc_nxt;
        end
    end

endmodule

// File: tb/tb_au_add_vz_dser.sv
// Scoreboard bench: directed cases plus random traffic on a 16/4 instance, random sweeps on 16/16, 16/1 and 1/1.
// Expected results come from an integer model of a + b + ci; a monitor per instance compares on every valid output.
// Random in_valid/out_ready toggling exercises backpressure and ignored inputs outside IDLE.
module tb_au_add_vz_dser;

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        v;
        logic        z;
        longint      acc;
    } exp_t;

    logic   clk = 1'b0;
    longint cyc = 0;
    int     checks = 0;
    int     errors = 0;
    bit     done [4];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Integer reference: unsigned sum for s/co, signed sum range test for v.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic c, input longint acc);
        longint m    = longint'(1) << w;
        longint ua   = longint'(a) % m;
        longint ub   = longint'(b) % m;
        longint full = ua + ub + longint'(c);
        longint sa   = (ua >= m / 2) ? ua - m : ua;
        longint sb   = (ub >= m / 2) ? ub - m : ub;
        longint ss   = sa + sb + longint'(c);
        exp_t   e;
        e.s   = 16'(full % m);
        e.co  = (full >= m);
        e.v   = (ss >= m / 2) || (ss < -(m / 2));
        e.z   = ((full % m) == 0);
        e.acc = acc;
        return e;
    endfunction

    function automatic logic [15:0] rnd16();
        logic [15:0] r;
        case ($urandom_range(0, 7))
            0:       r = 16'h0000;
            1:       r = 16'hFFFF;
            2:       r = 16'h8000;
            3:       r = 16'h7FFF;
            default: r = 16'($urandom);
        endcase
        return r;
    endfunction

    // ---------------- instance 0: WIDTH=16, DIGIT=4 ----------------
    logic        rst0_n, iv0, ir0, ci0, ov0, or0, co0, v0, z0;
    logic [15:0] a0, b0, s0;
    exp_t        q0[$];
    bit          seen0 = 1'b0;

    au_add_vz_dser #(.WIDTH(16), .DIGIT(4)) u0 (
        .clk(clk), .rst_n(rst0_n), .in_valid(iv0), .in_ready(ir0),
        .a(a0), .b(b0), .ci(ci0), .out_valid(ov0), .out_ready(or0),
        .s(s0), .co(co0), .v(v0), .z(z0)
    );

    always @(negedge clk) begin : mon0
        exp_t e;
        if (rst0_n && ov0) begin
            if (q0.size() == 0) begin
                check("u0 spurious out_valid", 1, 0);
            end else begin
                e = q0[0];
                if (!seen0) begin
                    check("u0 latency", cyc - e.acc, 4);
                    seen0 = 1'b1;
                end
                check("u0 s", s0, e.s);
                check("u0 co", co0, e.co);
                check("u0 v", v0, e.v);
                check("u0 z", z0, e.z);
                check("u0 in_ready in DONE", ir0, 0);
                if (or0) begin
                    void'(q0.pop_front());
                    seen0 = 1'b0;
                end
            end
        end
    end

    // Present an operand (called just after a rising edge) and hold it until accepted.
    task automatic op0(input logic [15:0] a, input logic [15:0] b, input logic c);
        int t = 0;
        iv0 = 1'b1; a0 = a; b0 = b; ci0 = c;
        @(negedge clk);
        while (!ir0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ir0) check("u0 accept timeout", 0, 1);
        else      q0.push_back(model(16, a, b, c, cyc + 1));
        @(posedge clk);
        #1 iv0 = 1'b0;
    endtask

    task automatic wait_ov0();
        int t = 0;
        @(negedge clk);
        while (!ov0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("u0 out_valid timeout", ov0, 1);
    endtask

    task automatic expect0(input logic [15:0] es, input logic eco, input logic ev, input logic ez);
        wait_ov0();
        check("u0 directed s", s0, es);
        check("u0 directed co", co0, eco);
        check("u0 directed v", v0, ev);
        check("u0 directed z", z0, ez);
        @(posedge clk);
        #1;
    endtask

    initial begin : stim0
        int n;
        int t;
        rst0_n = 1'b0; iv0 = 1'b0; a0 = '0; b0 = '0; ci0 = 1'b0; or0 = 1'b1;
        #2;
        check("u0 reset in_ready", ir0, 1);
        check("u0 reset out_valid", ov0, 0);
        check("u0 reset s", s0, 0);
        check("u0 reset flags", {co0, v0, z0}, 0);
        repeat (2) @(posedge clk);
        #1 rst0_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic add with cycle-exact handshake timing.
        op0(16'h1234, 16'h0001, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t1 in_ready busy", ir0, 0);
            check("t1 out_valid timing", ov0, (i == 4));
            if (i == 4) begin
                check("t1 s", s0, 16'h1235);
                check("t1 flags", {co0, v0, z0}, 3'b000);
            end
        end
        @(negedge clk);
        check("t1 in_ready after handoff", ir0, 1);
        @(posedge clk);
        #1;

        op0(16'h7FFF, 16'h0001, 1'b0); expect0(16'h8000, 1'b0, 1'b1, 1'b0);
        op0(16'h8000, 16'h8000, 1'b0); expect0(16'h0000, 1'b1, 1'b1, 1'b1);
        op0(16'hFFFF, 16'h0000, 1'b1); expect0(16'h0000, 1'b1, 1'b0, 1'b1);

        // Backpressure: result held while in_valid toggles with junk operands.
        or0 = 1'b0;
        op0(16'h1111, 16'h2222, 1'b0);
        wait_ov0();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 iv0 = ~iv0; a0 = rnd16(); b0 = rnd16(); ci0 = 1'($urandom);
            @(negedge clk);
            check("t4 out_valid held", ov0, 1);
            check("t4 in_ready low", ir0, 0);
            check("t4 s stable", s0, 16'h3333);
            check("t4 flags stable", {co0, v0, z0}, 3'b000);
        end
        @(posedge clk);
        #1 iv0 = 1'b0; or0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t4 released out_valid", ov0, 0);
        check("t4 released in_ready", ir0, 1);
        @(posedge clk);
        #1;
        op0(16'h00FF, 16'h0F01, 1'b1); expect0(16'h1001, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset after two digits of an in-flight add.
        op0(16'h1234, 16'h4321, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3 rst0_n = 1'b0;
        q0.delete();
        #1;
        check("t5 reset out_valid", ov0, 0);
        check("t5 reset in_ready", ir0, 1);
        check("t5 reset s", s0, 0);
        check("t5 reset flags", {co0, v0, z0}, 3'b000);
        @(posedge clk);
        #1 rst0_n = 1'b1;
        @(posedge clk);
        #1;
        op0(16'h0F0F, 16'hF0F1, 1'b0); expect0(16'h0000, 1'b1, 1'b0, 1'b1);

        // Random traffic with random valid/ready.
        n = 0;
        t = 0;
        while (n < 300 && t < 20000) begin
            @(negedge clk);
            if (iv0 && ir0) begin
                q0.push_back(model(16, a0, b0, ci0, cyc + 1));
                n++;
            end
            @(posedge clk);
            #1;
            iv0 = ($urandom_range(0, 9) < 7);
            a0  = rnd16();
            b0  = rnd16();
            ci0 = 1'($urandom);
            or0 = ($urandom_range(0, 9) < 6);
            t++;
        end
        check("u0 random accepts", n, 300);
        iv0 = 1'b0;
        or0 = 1'b1;
        t = 0;
        while (q0.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("u0 drain", q0.size(), 0);
        done[0] = 1'b1;
    end

    // ---------------- parameter sweep: 16/16, 16/1, 1/1 ----------------
    for (genvar g = 1; g < 4; g++) begin : sw
        localparam int W = (g == 3) ? 1 : 16;
        localparam int D = (g == 1) ? 16 : 1;
        localparam int N = W / D;

        logic         rn, iv, ir, cin, ov, ordy, co_o, v_o, z_o;
        logic [W-1:0] ai, bi, so;
        exp_t         q[$];
        bit           seen = 1'b0;

        au_add_vz_dser #(.WIDTH(W), .DIGIT(D)) dut (
            .clk(clk), .rst_n(rn), .in_valid(iv), .in_ready(ir),
            .a(ai), .b(bi), .ci(cin), .out_valid(ov), .out_ready(ordy),
            .s(so), .co(co_o), .v(v_o), .z(z_o)
        );

        always @(negedge clk) begin : mon
            exp_t e;
            if (rn && ov) begin
                if (q.size() == 0) begin
                    check($sformatf("sw%0d spurious out_valid", g), 1, 0);
                end else begin
                    e = q[0];
                    if (!seen) begin
                        check($sformatf("sw%0d latency", g), cyc - e.acc, N);
                        seen = 1'b1;
                    end
                    check($sformatf("sw%0d s", g), so, e.s);
                    check($sformatf("sw%0d co", g), co_o, e.co);
                    check($sformatf("sw%0d v", g), v_o, e.v);
                    check($sformatf("sw%0d z", g), z_o, e.z);
                    check($sformatf("sw%0d in_ready in DONE", g), ir, 0);
                    if (ordy) begin
                        void'(q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end

        initial begin : stim
            int n;
            int t;
            rn = 1'b0; iv = 1'b0; ai = '0; bi = '0; cin = 1'b0; ordy = 1'b0;
            #2;
            check($sformatf("sw%0d reset in_ready", g), ir, 1);
            check($sformatf("sw%0d reset out_valid", g), ov, 0);
            repeat (2) @(posedge clk);
            #1 rn = 1'b1;
            n = 0;
            t = 0;
            while (n < 1000 && t < 60000) begin
                @(negedge clk);
                if (iv && ir) begin
                    q.push_back(model(W, 16'(ai), 16'(bi), cin, cyc + 1));
                    n++;
                end
                @(posedge clk);
                #1;
                iv   = ($urandom_range(0, 9) < 7);
                ai   = W'(rnd16());
                bi   = W'(rnd16());
                cin  = 1'($urandom);
                ordy = ($urandom_range(0, 9) < 6);
                t++;
            end
            check($sformatf("sw%0d random accepts", g), n, 1000);
            iv   = 1'b0;
            ordy = 1'b1;
            t = 0;
            while (q.size() != 0 && t < 200) begin
                @(posedge clk);
                t++;
            end
            check($sformatf("sw%0d drain", g), q.size(), 0);
            done[g] = 1'b1;
        end
    end

    initial begin : finish_blk
        int t = 0;
        while (!(done[0] && done[1] && done[2] && done[3]) && t < 90000) begin
            @(posedge clk);
            t++;
        end
        check("all streams finished", done[0] && done[1] && done[2] && done[3], 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
